// File: rtl/platform_pkg.sv
// rtl/platform_pkg.sv - shared types, constants and kind mapping for the platform spawner
// Contents:
//   plat_kind_t     platform kind encoding
//   spawn_state_t   spawner FSM states
//   SCREEN_W_PX     default playfield width in pixels
//   PLAT_W_PX       default platform sprite width in pixels
//   kind_from_rnd   3 random bits -> kind (0-5 normal, 6 moving, 7 breaking)
package platform_pkg;

  typedef enum logic [1:0] {
    PLAT_NORMAL   = 2'd0,
    PLAT_MOVING   = 2'd1,
    PLAT_BREAKING = 2'd2
  } plat_kind_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_CHECK  = 2'd2,
    S_HOLD   = 2'd3
  } spawn_state_t;

  localparam int SCREEN_W_PX = 640;
  localparam int PLAT_W_PX   = 60;

  function automatic plat_kind_t kind_from_rnd(input logic [2:0] bits);
    case (bits)
      3'd6:    return PLAT_MOVING;
      3'd7:    return PLAT_BREAKING;
      default: return PLAT_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/platform_candidate_check.sv
// rtl/platform_candidate_check.sv - combinational range/reachability check and kind demotion
// Ports:
//   cand_x      in   candidate left x
//   cand_kind   in   candidate kind
//   prev_x      in   left x of the previously accepted platform
//   prev_kind   in   kind of the previously accepted platform
//   accept      out  candidate fits on screen and is within reach of prev_x
//   final_kind  out  candidate kind after breaking-after-breaking demotion
module platform_candidate_check
  import platform_pkg::*;
#(
  parameter int SCREEN_W = platform_pkg::SCREEN_W_PX,
  parameter int PLAT_W   = platform_pkg::PLAT_W_PX,
  parameter int MAX_DX   = 200
) (
  input  logic [9:0]  cand_x,
  input  plat_kind_t  cand_kind,
  input  logic [9:0]  prev_x,
  input  plat_kind_t  prev_kind,
  output logic        accept,
  output plat_kind_t  final_kind
);

  localparam logic [9:0]  X_MAX  = 10'(SCREEN_W - PLAT_W);
  localparam logic [10:0] DX_MAX = 11'(MAX_DX);

  // Zero-extended to 11 bits so the signed difference cannot wrap.
  logic signed [10:0] diff;
  logic        [10:0] adiff;

  always_comb begin
    diff  = $signed({1'b0, cand_x}) - $signed({1'b0, prev_x});
    adiff = diff[10] ? 11'(-diff) : 11'(diff);
    accept = (cand_x <= X_MAX) && (adiff <= DX_MAX);
    // Two breaking platforms in a row would strand the player: demote, don't reject.
    if (cand_kind == PLAT_BREAKING && prev_kind == PLAT_BREAKING)
      final_kind = PLAT_NORMAL;
    else
      final_kind = cand_kind;
  end

endmodule

// File: rtl/platform_spawner.sv
// rtl/platform_spawner.sv - turns random words into reachable platform descriptors
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   rnd                  free-running 15-bit random word
//   req, req_y           platform request and its y row
//   req_ready            idle; a request is taken on this edge if req=1
//   plat_valid/ready     descriptor handshake towards the platform table
//   plat_x, plat_y       descriptor position
//   plat_kind            descriptor kind (plat_kind_t)
//   plat_fallback        descriptor came from the fallback path
module platform_spawner
  import platform_pkg::*;
#(
  parameter int SCREEN_W  = platform_pkg::SCREEN_W_PX,
  parameter int PLAT_W    = platform_pkg::PLAT_W_PX,
  parameter int MAX_DX    = 200,
  parameter int MAX_TRIES = 8,
  parameter int Y_W       = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [14:0]    rnd,
  input  logic           req,
  input  logic [Y_W-1:0] req_y,
  output logic           req_ready,
  output logic           plat_valid,
  input  logic           plat_ready,
  output logic [9:0]     plat_x,
  output logic [Y_W-1:0] plat_y,
  output logic [1:0]     plat_kind,
  output logic           plat_fallback
);

  localparam int          TRY_W  = $clog2(MAX_TRIES + 1);
  localparam logic [9:0]  X_HOME = 10'((SCREEN_W - PLAT_W) / 2);

  spawn_state_t      state;
  logic [TRY_W-1:0]  tries;
  logic [9:0]        cand_x;
  plat_kind_t        cand_kind;
  logic [9:0]        prev_x;
  plat_kind_t        prev_kind;
  logic              accept;
  plat_kind_t        final_kind;

  // rnd[11:10] carry no meaning for placement.
  logic unused_rnd;
  assign unused_rnd = ^rnd[11:10];

  platform_candidate_check #(
    .SCREEN_W (SCREEN_W),
    .PLAT_W   (PLAT_W),
    .MAX_DX   (MAX_DX)
  ) u_check (
    .cand_x     (cand_x),
    .cand_kind  (cand_kind),
    .prev_x     (prev_x),
    .prev_kind  (prev_kind),
    .accept     (accept),
    .final_kind (final_kind)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      req_ready     <= 1'b1;
      plat_valid    <= 1'b0;
      plat_x        <= '0;
      plat_y        <= '0;
      plat_kind     <= PLAT_NORMAL;
      plat_fallback <= 1'b0;
      tries         <= '0;
      cand_x        <= '0;
      cand_kind     <= PLAT_NORMAL;
      prev_x        <= X_HOME;
      prev_kind     <= PLAT_NORMAL;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            plat_y    <= req_y;
            tries     <= '0;
            req_ready <= 1'b0;
            state     <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          cand_x    <= rnd[9:0];
          cand_kind <= kind_from_rnd(rnd[14:12]);
          tries     <= tries + 1'b1;
          state     <= S_CHECK;
        end
        S_CHECK: begin
          if (accept) begin
            plat_x        <= cand_x;
            plat_kind     <= final_kind;
            plat_fallback <= 1'b0;
            plat_valid    <= 1'b1;
            state         <= S_HOLD;
          end else if (tries == TRY_W'(MAX_TRIES)) begin
            // Out of attempts: stack directly on the previous platform, always reachable.
            plat_x        <= prev_x;
            plat_kind     <= PLAT_NORMAL;
            plat_fallback <= 1'b1;
            plat_valid    <= 1'b1;
            state         <= S_HOLD;
          end else begin
            state <= S_SAMPLE;
          end
        end
        S_HOLD: begin
          if (plat_ready) begin
            prev_x     <= plat_x;
            prev_kind  <= plat_kind_t'(plat_kind);
            plat_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/platform_spawner.md
Name: platform_spawner

Overview:
Consumer side of the game's random-number path. Takes the free-running 15-bit random word and, on request from the scroll logic, turns it into one reachable platform descriptor: x position, y row and kind. Uses rejection sampling, a bounded retry count and a deterministic fallback. Sits between the random source and the platform table; valid/ready handshake on both sides.

Parameters:
SCREEN_W, 640, visible playfield width in pixels
PLAT_W, 60, platform sprite width in pixels
MAX_DX, 200, max allowed |x - prev_x| so the player can reach the platform (inclusive)
MAX_TRIES, 8, rejection attempts before fallback
Y_W, 10, width of y row coordinate

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset)
rnd  in  15  random word, may change every cycle
req  in  1  scroll logic requests a platform
req_y  in  Y_W  y row for the requested platform
req_ready  out  1  spawner idle, request accepted this cycle if req=1
plat_valid  out  1  descriptor available
plat_ready  in  1  platform table accepts descriptor
plat_x  out  10  left x of platform
plat_y  out  Y_W  y row (latched req_y)
plat_kind  out  2  plat_kind_t
plat_fallback  out  1  descriptor produced by fallback path

Behaviour:
- rnd field use: cand_x = rnd[9:0]; rnd[14:12] maps to kind: 0-5 NORMAL, 6 MOVING, 7 BREAKING.
- Reset (rst=0 at an edge): state IDLE; req_ready=1; plat_valid=0; plat_x=0; plat_y=0; plat_kind=NORMAL; plat_fallback=0; tries=0; prev_x=(SCREEN_W-PLAT_W)/2=290; prev_kind=NORMAL. Reset mid-operation discards any in-flight or held descriptor.
- FSM IDLE -> SAMPLE -> CHECK -> (SAMPLE | HOLD) -> IDLE.
- IDLE: req_ready=1. On an edge with req=1, latch req_y, clear tries, go to SAMPLE. req is ignored in all other states (req_ready=0).
- SAMPLE: at the edge, register cand_x and cand_kind from rnd, increment tries, go to CHECK.
- CHECK: accept if cand_x <= SCREEN_W-PLAT_W and |cand_x - prev_x| <= MAX_DX. Compute the difference as an 11-bit signed value; no wrap.
  - Accept: go to HOLD with plat_x=cand_x and plat_fallback=0.
  - Reject and tries < MAX_TRIES: go back to SAMPLE.
  - Reject and tries == MAX_TRIES: go to HOLD with plat_x=prev_x, kind NORMAL, plat_fallback=1.
- Kind rule (applied on accept): BREAKING after a prev_kind of BREAKING is demoted to NORMAL. This is a demotion, not a rejection.
- Latency: a best-case accept raises plat_valid 2 edges after the accepting edge. Each rejection adds 2 edges. Worst case is 2*MAX_TRIES edges.
- HOLD: plat_valid=1. plat_x, plat_y, plat_kind and plat_fallback stay stable while plat_ready=0, regardless of rnd or req.
- Handshake: on an edge with plat_valid && plat_ready, update prev_x and prev_kind from the outputs, drop plat_valid, go to IDLE. req_ready is high in the next cycle, so there is no back-to-back acceptance in the handshake cycle.
- Output registers keep their last values after the handshake; only plat_valid qualifies them.

Decomposition:
- Package platform_pkg:
  - typedef enum logic [1:0] plat_kind_t {PLAT_NORMAL=0, PLAT_MOVING=1, PLAT_BREAKING=2}
  - SCREEN_W and PLAT_W constants
  - kind-mapping function from 3 random bits to plat_kind_t
- One natural sub-module, platform_candidate_check: combinational range, reachability and kind-demotion check, returning accept and final kind. It is reused later by the moving-platform updater.

Test Plan:
- Reset, then release rst=1 -> req_ready=1, plat_valid=0, plat_x=0, plat_kind=NORMAL, plat_fallback=0; internal prev_x=290.
- rnd=0x0190 held, req=1 with req_y=100 for one edge -> plat_valid high after 2 edges, plat_x=400, plat_y=100, kind NORMAL, plat_fallback=0.
- After a handshake (prev_x=400): rnd=0x0258 (600, >580) for the first sample, then 0x00C8 -> first candidate rejected, plat_valid after 4 edges, plat_x=200 (|diff|=200 is the inclusive boundary).
- rnd=0x03FF held -> 8 rejections, plat_valid after 16 edges, plat_x=prev_x, kind NORMAL, plat_fallback=1.
- Two consecutive requests each with rnd=0x7190 -> first yields BREAKING x=400; second yields NORMAL x=400 (demotion).
- plat_ready=0 for 5 cycles while rnd toggles and req=1 -> outputs unchanged, req_ready=0. Then plat_ready=1 -> one handshake, IDLE. Separately, rst=0 during CHECK -> IDLE, plat_valid=0 next cycle, prev_x=290.
